spi_flash_responder: RTL and testbench

- Synthesizable SPI NOR-flash target emulator: the serial-flash end of the card's boot-time flash load path.
- Used in the FPGA emulation/verification harness in place of the physical flash chip.
- Serves single-read (0x03), dual-output fast read (0x3B) and read-status (0x05) from a byte-wide backing-memory read port.
- Oversamples the SPI pins in the C25M domain.

---
 rtl/spi_flash_responder_if.sv | 22 ++
 rtl/spi_flash_responder.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// ============================================================================
//  Module   : spi_flash_responder_if
//  Purpose  : Byte-wide backing-memory read port of the SPI flash responder.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface spi_flash_responder_if #(
   parameter int ADDR_W = 24
);
   logic [ADDR_W-1:0] MemAddr;
   logic              MemReq;
   logic              MemAck;
   logic [7:0]        MemData;

   // master: the responder issuing reads; slave: the memory answering them
   modport master (output MemAddr, output MemReq, input MemAck, input MemData);
   modport slave  (input MemAddr, input MemReq, output MemAck, output MemData);
endinterface

`default_nettype wire

// File: rtl/spi_flash_responder.sv
// ============================================================================
//  Module   : spi_flash_responder
//  Purpose  : SPI NOR-flash target emulator (0x03, 0x3B, 0x05) oversampled in
//             the C25M domain. Optional 0x9F JEDEC ID: SPI_FLASH_JEDEC_ID_EN.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_flash_responder #(
   parameter int          ADDR_W     = 24,
   parameter logic [7:0]  STATUS_VAL = 8'h00
`ifdef SPI_FLASH_JEDEC_ID_EN
   ,
   parameter logic [23:0] JEDEC_ID   = 24'hEF4018
`endif
) (
   input  wire logic C25M,
   input  wire logic RES,
   input  wire logic nFCS,
   input  wire logic FCK,
   input  wire logic MOSIin,
   output logic      MOSIout,
   output logic      MOSIOE,
   output logic      MISOout,
   output logic      MISOOE,
   output logic      Underrun,
   spi_flash_responder_if.master mem
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DUMMY  = 3'd3,
      ST_DATA   = 3'd4,
      ST_STAT   = 3'd5,
      ST_IGNORE = 3'd6
`ifdef SPI_FLASH_JEDEC_ID_EN
      ,
      ST_ID     = 3'd7
`endif
   } state_t;

   localparam logic [4:0]        ADDR_LAST = 5'(ADDR_W - 1);
   localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(1);

   state_t            state, state_nx;
   logic [4:0]        bit_cnt, bit_cnt_nx;
   logic              nfcs_s1, nfcs_s2;
   logic              fck_s1, fck_s2, fck_d;
   logic              mosi_s1, mosi_s2;
   logic              fck_rise, fck_fall, selected;
   logic [7:0]        cmd, cmd_shift;
   logic              dual;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_req, req_want, stale;
   logic [7:0]        pbuf;
   logic              pbuf_valid;
   logic [7:0]        shreg;
   logic [7:0]        load_byte;
   logic              addr_done, load, ack_take, drop_ack;
   logic              miso_q, mosi_q, miso_oe_q, mosi_oe_q, underrun_q;

   // chip select resets to the deselected level so reset release cannot start a command
   always_ff @(posedge C25M or posedge RES) begin
      if (RES) begin
         nfcs_s1 <= 1'b1;
         nfcs_s2 <= 1'b1;
         fck_s1  <= 1'b0;
         fck_s2  <= 1'b0;
         fck_d   <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         nfcs_s1 <= nFCS;
         nfcs_s2 <= nfcs_s1;
         fck_s1  <= FCK;
         fck_s2  <= fck_s1;
         fck_d   <= fck_s2;
         mosi_s1 <= MOSIin;
         mosi_s2 <= mosi_s1;
      end
   end

   assign fck_rise  = fck_s2 & ~fck_d;
   assign fck_fall  = ~fck_s2 & fck_d;
   assign selected  = ~nfcs_s2;
   assign dual      = (cmd == 8'h3B);
   assign load_byte = pbuf_valid ? pbuf : 8'hFF;
   assign ack_take  = mem_req & mem.MemAck;
   // late data for an abandoned fetch must never reach the prefetch buffer
   assign drop_ack  = ~selected | stale | (load & ~pbuf_valid);

   always_ff @(posedge C25M or posedge RES) begin
      if (RES) begin
         state   <= ST_IDLE;
         bit_cnt <= 5'd0;
      end else begin
         state   <= state_nx;
         bit_cnt <= bit_cnt_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      cmd_shift  = {cmd[6:0], mosi_s2};
      addr_done  = 1'b0;
      load       = 1'b0;
      if (!selected) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_nx = ST_CMD;
            ST_CMD: begin
               if (fck_rise) begin
                  bit_cnt_nx = bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     case (cmd_shift)
                        8'h03, 8'h3B: state_nx = ST_ADDR;
                        8'h05:        state_nx = ST_STAT;
`ifdef SPI_FLASH_JEDEC_ID_EN
                        8'h9F:        state_nx = ST_ID;
`endif
                        default:      state_nx = ST_IGNORE;
                     endcase
                  end
               end
            end
            ST_ADDR: begin
               if (fck_rise) begin
                  bit_cnt_nx = bit_cnt + 5'd1;
                  if (bit_cnt == ADDR_LAST) begin
                     addr_done = 1'b1;
                     state_nx  = dual ? ST_DUMMY : ST_DATA;
                  end
               end
            end
            ST_DUMMY: begin
               if (fck_rise) begin
                  bit_cnt_nx = bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) state_nx = ST_DATA;
               end
            end
            ST_DATA: begin
               // bit_cnt counts falls within the current byte; zero is the load point
               if (fck_fall) begin
                  load       = (bit_cnt == 5'd0);
                  bit_cnt_nx = (bit_cnt == (dual ? 5'd3 : 5'd7)) ? 5'd0 : bit_cnt + 5'd1;
               end
            end
            ST_STAT: begin
               if (fck_fall) bit_cnt_nx = {2'b00, bit_cnt[2:0] + 3'd1};
            end
`ifdef SPI_FLASH_JEDEC_ID_EN
            ST_ID: begin
               if (fck_fall) bit_cnt_nx = (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
            end
`endif
            default: ;
         endcase
      end
      if (state_nx != state) bit_cnt_nx = 5'd0;
   end

   always_ff @(posedge C25M or posedge RES) begin
      if (RES) begin
         cmd        <= 8'h00;
         mem_addr   <= '0;
         mem_req    <= 1'b0;
         req_want   <= 1'b0;
         stale      <= 1'b0;
         pbuf       <= 8'h00;
         pbuf_valid <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         if (state == ST_CMD && fck_rise && selected) cmd <= cmd_shift;
         if (state == ST_ADDR && fck_rise && selected)
            mem_addr <= {mem_addr[ADDR_W-2:0], mosi_s2};
         if (load) mem_addr <= mem_addr + ADDR_INC;

         if (ack_take) begin
            mem_req <= 1'b0;
            stale   <= 1'b0;
            if (!drop_ack) begin
               pbuf       <= mem.MemData;
               pbuf_valid <= 1'b1;
            end
         end else if (!mem_req && req_want) begin
            mem_req  <= 1'b1;
            req_want <= 1'b0;
         end

         // a new fetch waits for any outstanding request to be acknowledged first
         if (addr_done || load) begin
            if (mem_req) begin
               req_want <= 1'b1;
            end else begin
               mem_req  <= 1'b1;
               req_want <= 1'b0;
            end
         end

         if (addr_done) pbuf_valid <= 1'b0;
         if (load) begin
            pbuf_valid <= 1'b0;
            if (!pbuf_valid) begin
               underrun_q <= 1'b1;
               if (mem_req && !mem.MemAck) stale <= 1'b1;
            end
         end

         if (!selected) begin
            pbuf_valid <= 1'b0;
            req_want   <= 1'b0;
            if (mem_req && !mem.MemAck) stale <= 1'b1;
         end
      end
   end

   always_ff @(posedge C25M or posedge RES) begin
      if (RES) begin
         shreg     <= 8'h00;
         miso_q    <= 1'b0;
         mosi_q    <= 1'b0;
         miso_oe_q <= 1'b0;
         mosi_oe_q <= 1'b0;
      end else if (!selected) begin
         miso_q    <= 1'b0;
         mosi_q    <= 1'b0;
         miso_oe_q <= 1'b0;
         mosi_oe_q <= 1'b0;
      end else begin
         case (state)
            ST_DATA: begin
               if (fck_fall) begin
                  miso_oe_q <= 1'b1;
                  mosi_oe_q <= dual;
                  if (load) begin
                     miso_q <= load_byte[7];
                     mosi_q <= dual & load_byte[6];
                     shreg  <= dual ? {load_byte[5:0], 2'b00} : {load_byte[6:0], 1'b0};
                  end else begin
                     miso_q <= shreg[7];
                     mosi_q <= dual & shreg[6];
                     shreg  <= dual ? {shreg[5:0], 2'b00} : {shreg[6:0], 1'b0};
                  end
               end
            end
            ST_STAT: begin
               if (fck_fall) begin
                  miso_oe_q <= 1'b1;
                  miso_q    <= STATUS_VAL[3'd7 - bit_cnt[2:0]];
               end
            end
`ifdef SPI_FLASH_JEDEC_ID_EN
            ST_ID: begin
               if (fck_fall) begin
                  miso_oe_q <= 1'b1;
                  miso_q    <= JEDEC_ID[5'd23 - bit_cnt];
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign MISOout     = miso_q;
   assign MOSIout     = mosi_q;
   assign MISOOE      = miso_oe_q;
   assign MOSIOE      = mosi_oe_q;
   assign Underrun    = underrun_q;
   assign mem.MemAddr = mem_addr;
   assign mem.MemReq  = mem_req;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
// ============================================================================
//  Module   : tb_spi_flash_responder
//  Purpose  : Directed self-checking bench for spi_flash_responder.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_flash_responder;

   localparam int HALF = 6;

   logic C25M, RES, nFCS, FCK, MOSIin;
   logic MOSIout, MOSIOE, MISOout, MISOOE, Underrun;

   spi_flash_responder_if #(.ADDR_W(24)) mif ();

   spi_flash_responder #(
      .ADDR_W     (24),
      .STATUS_VAL (8'h9C)
   ) dut (
      .C25M     (C25M),
      .RES      (RES),
      .nFCS     (nFCS),
      .FCK      (FCK),
      .MOSIin   (MOSIin),
      .MOSIout  (MOSIout),
      .MOSIOE   (MOSIOE),
      .MISOout  (MISOout),
      .MISOOE   (MISOOE),
      .Underrun (Underrun),
      .mem      (mif)
   );

   initial begin
      C25M = 1'b0;
      forever #5 C25M = ~C25M;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // memory model: captures the address when it accepts a request
   logic [7:0]  mem [logic [23:0]];
   int          req_cnt, req_mark, slow_idx, dly;
   logic        busy;
   logic [23:0] lat_addr;

   function automatic logic [7:0] mem_rd(input logic [23:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   always @(posedge C25M or posedge RES) begin
      if (RES) begin
         busy        <= 1'b0;
         mif.MemAck  <= 1'b0;
         mif.MemData <= 8'h00;
         dly         <= 0;
         req_cnt     <= 0;
      end else begin
         mif.MemAck <= 1'b0;
         if (busy) begin
            if (dly == 0) begin
               mif.MemAck  <= 1'b1;
               mif.MemData <= mem_rd(lat_addr);
               busy        <= 1'b0;
            end else begin
               dly <= dly - 1;
            end
         end else if (mif.MemReq && !mif.MemAck) begin
            busy     <= 1'b1;
            lat_addr <= mif.MemAddr;
            req_cnt  <= req_cnt + 1;
            dly      <= (req_cnt + 1 - req_mark == slow_idx) ? 200 : 0;
         end
      end
   end

   int n_checks, n_pass;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   logic [63:0] cap1, cap0;
   logic        oe1_all, oe1_any, oe0_any;

   task automatic cs_low();
      nFCS = 1'b0;
      repeat (6) @(negedge C25M);
   endtask

   task automatic cs_high();
      nFCS = 1'b1;
      repeat (12) @(negedge C25M);
   endtask

   // header bits go out MSB first; samples start at the fall of the last header clock
   task automatic xfer(input logic [63:0] hdr, input int hbits, input int ndata);
      int total, first;
      total   = (hbits == 0) ? ndata : hbits + ndata - 1;
      first   = total - ndata;
      cap1    = '0;
      cap0    = '0;
      oe1_all = 1'b1;
      oe1_any = 1'b0;
      oe0_any = 1'b0;
      for (int i = 0; i < total; i++) begin
         MOSIin = (i < hbits) ? hdr[hbits-1-i] : 1'b0;
         repeat (HALF) @(negedge C25M);
         FCK = 1'b1;
         repeat (HALF) @(negedge C25M);
         FCK = 1'b0;
         repeat (HALF) @(negedge C25M);
         if (i >= first) begin
            cap1    = {cap1[62:0], MISOout};
            cap0    = {cap0[62:0], MOSIout};
            oe1_all = oe1_all & MISOOE;
            oe1_any = oe1_any | MISOOE;
            oe0_any = oe0_any | MOSIOE;
         end
      end
   endtask

   logic [31:0] dword;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      req_mark = 0;
      slow_idx = -1;
      RES      = 1'b1;
      nFCS     = 1'b1;
      FCK      = 1'b0;
      MOSIin   = 1'b0;
      mem[24'h000000] = 8'hA5;
      mem[24'h000001] = 8'h3C;
      mem[24'h000002] = 8'hFF;
      mem[24'h000003] = 8'h00;
      mem[24'h000010] = 8'hC3;
      mem[24'h000100] = 8'h5A;
      mem[24'h000101] = 8'h77;
      mem[24'h000200] = 8'h99;
      mem[24'hFFFFFF] = 8'h12;

      repeat (5) @(negedge C25M);
      chk("rst_misooe",   {63'd0, MISOOE},   64'd0);
      chk("rst_mosioe",   {63'd0, MOSIOE},   64'd0);
      chk("rst_misoout",  {63'd0, MISOout},  64'd0);
      chk("rst_mosiout",  {63'd0, MOSIout},  64'd0);
      chk("rst_memreq",   {63'd0, mif.MemReq}, 64'd0);
      chk("rst_memaddr",  {40'd0, mif.MemAddr}, 64'd0);
      chk("rst_underrun", {63'd0, Underrun}, 64'd0);
      RES = 1'b0;
      repeat (5) @(negedge C25M);

      // dual-output fast read of A5 3C FF 00
      cs_low();
      xfer({24'd0, 8'h3B, 24'h000000, 8'h00}, 40, 16);
      dword = '0;
      for (int i = 15; i >= 0; i--) dword = {dword[29:0], cap1[i], cap0[i]};
      cs_high();
      chk("dual_b0", {56'd0, dword[31:24]}, 64'hA5);
      chk("dual_b1", {56'd0, dword[23:16]}, 64'h3C);
      chk("dual_b2", {56'd0, dword[15:8]},  64'hFF);
      chk("dual_b3", {56'd0, dword[7:0]},   64'h00);
      chk("dual_misooe", {63'd0, oe1_all},  64'd1);
      chk("dual_mosioe", {63'd0, oe0_any},  64'd1);
      chk("dual_underrun", {63'd0, Underrun}, 64'd0);

      // single read wrapping from the top address
      mem[24'h000000] = 8'h34;
      cs_low();
      xfer({32'd0, 8'h03, 24'hFFFFFF}, 32, 8);
      chk("wrap_b0", cap1, 64'h12);
      chk("wrap_addr", {40'd0, mif.MemAddr}, 64'h000000);
      chk("wrap_oe1a", {63'd0, oe1_all}, 64'd1);
      chk("wrap_oe0a", {63'd0, oe0_any}, 64'd0);
      xfer(64'd0, 0, 8);
      chk("wrap_b1", cap1, 64'h34);
      chk("wrap_oe0b", {63'd0, oe0_any}, 64'd0);
      cs_high();

      // slow memory on the second fetch
      req_mark = req_cnt;
      slow_idx = 2;
      cs_low();
      xfer({32'd0, 8'h03, 24'h000100}, 32, 16);
      cs_high();
      slow_idx = -1;
      repeat (250) @(negedge C25M);
      chk("slow_bytes", cap1, 64'h5AFF);
      chk("slow_underrun", {63'd0, Underrun}, 64'd1);

      // status register, unknown command, JEDEC ID
      cs_low();
      xfer({56'd0, 8'h05}, 8, 16);
      cs_high();
      chk("stat_bytes", cap1, 64'h9C9C);
      chk("stat_oe", {63'd0, oe1_all}, 64'd1);

      cs_low();
      xfer({56'd0, 8'hAB}, 8, 16);
      cs_high();
      chk("unk_misooe", {63'd0, oe1_any}, 64'd0);
      chk("unk_mosioe", {63'd0, oe0_any}, 64'd0);

      cs_low();
      xfer({56'd0, 8'h9F}, 8, 24);
      cs_high();
`ifdef SPI_FLASH_JEDEC_ID_EN
      chk("id_bytes", cap1, 64'hEF4018);
      chk("id_oe", {63'd0, oe1_all}, 64'd1);
`else
      chk("id_nodrive", {63'd0, oe1_any}, 64'd0);
`endif
      chk("underrun_sticky", {63'd0, Underrun}, 64'd1);

      // abort a dual read after three falls, then a fresh single read
      mem[24'h000000] = 8'hA5;
      cs_low();
      xfer({24'd0, 8'h3B, 24'h000000, 8'h00}, 40, 3);
      chk("abort_io1", cap1, 64'b110);
      chk("abort_io0", cap0, 64'b001);
      chk("abort_oe_on", {62'd0, MISOOE, MOSIOE}, 64'b11);
      nFCS = 1'b1;
      repeat (4) @(negedge C25M);
      chk("abort_oe_off", {62'd0, MISOOE, MOSIOE}, 64'b00);
      repeat (20) @(negedge C25M);
      cs_low();
      xfer({32'd0, 8'h03, 24'h000010}, 32, 8);
      cs_high();
      chk("abort_newread", cap1, 64'hC3);

      // reset while a fetch is still outstanding
      req_mark = req_cnt;
      slow_idx = 1;
      cs_low();
      xfer({32'd0, 8'h03, 24'h000200}, 32, 1);
      chk("midrst_reqheld", {63'd0, mif.MemReq}, 64'd1);
      RES = 1'b1;
      @(negedge C25M);
      chk("midrst_memreq",   {63'd0, mif.MemReq}, 64'd0);
      chk("midrst_memaddr",  {40'd0, mif.MemAddr}, 64'd0);
      chk("midrst_underrun", {63'd0, Underrun}, 64'd0);
      chk("midrst_misooe",   {63'd0, MISOOE}, 64'd0);
      nFCS     = 1'b1;
      slow_idx = -1;
      repeat (5) @(negedge C25M);
      RES = 1'b0;
      repeat (5) @(negedge C25M);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
